param_data_path: RTL

//  Parametrised CPU datapath: NUM_REGS-entry register file plus HI, LO, Zhigh, Zlow, PC, MDR, InPort and Y,
//  all sharing one encoded-select bus. ALU ops are single-cycle. MUL/DIV run on a multi-cycle iterative

---
 rtl/data_path_pkg.sv | 27 ++
 rtl/param_data_path_if.sv | 44 ++++
 rtl/iter_muldiv.sv | 139 +++++++++++++
 rtl/param_data_path.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/data_path_pkg.sv
// Opcodes and bus-source offsets shared by the datapath, its interface users and the mul/div unit.
// Bus-source offsets are added to NUM_REGS to form the full select code.
package data_path_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_NEG  = 5'd9;
    localparam logic [4:0] OP_NOT  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd12;

    localparam int SRC_HI     = 0;
    localparam int SRC_LO     = 1;
    localparam int SRC_ZHIGH  = 2;
    localparam int SRC_ZLOW   = 3;
    localparam int SRC_PC     = 4;
    localparam int SRC_MDR    = 5;
    localparam int SRC_INPORT = 6;

endpackage

// File: rtl/param_data_path_if.sv
// Control/memory-side signal bundle of the datapath; master = control unit, slave = datapath.
// Select widths are derived here so both sides agree.
interface param_data_path_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
);
    localparam int SEL_W  = $clog2(NUM_REGS + 8);
    localparam int RSEL_W = $clog2(NUM_REGS);

    logic [SEL_W-1:0]  bus_sel;
    logic              reg_wr_en;
    logic [RSEL_W-1:0] reg_wr_sel;
    logic              HIin;
    logic              LOin;
    logic              PCin;
    logic              Yin;
    logic              Zin;
    logic              MDRin;
    logic              Read;
    logic [DATA_W-1:0] MDataIn;
    logic              InPortin;
    logic [DATA_W-1:0] in_port_data;
    logic [4:0]        alu_op;
    logic              alu_start;
    logic [DATA_W-1:0] bus_out;
    logic [DATA_W-1:0] mdr_out;
    logic [DATA_W-1:0] pc_out;
    logic              busy;
    logic              done;
    logic              div_zero;

    modport master (
        output bus_sel, reg_wr_en, reg_wr_sel, HIin, LOin, PCin, Yin, Zin,
        output MDRin, Read, MDataIn, InPortin, in_port_data, alu_op, alu_start,
        input  bus_out, mdr_out, pc_out, busy, done, div_zero
    );

    modport slave (
        input  bus_sel, reg_wr_en, reg_wr_sel, HIin, LOin, PCin, Yin, Zin,
        input  MDRin, Read, MDataIn, InPortin, in_port_data, alu_op, alu_start,
        output bus_out, mdr_out, pc_out, busy, done, div_zero
    );

endinterface

// File: rtl/iter_muldiv.sv
// Iterative signed multiply / divide: 1 sign-prep cycle + DATA_W shift cycles; divide-by-zero ends after prep.
// done/hi/lo are valid in the final busy cycle and are captured by the parent on the closing edge; start ignored while busy.
module iter_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              op,        // 1 = divide, 0 = multiply
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_op;
    logic              r_busy;
    logic              r_div_zero;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_m;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_div_sh;
    logic [DATA_W:0]     w_div_diff;
    logic                w_div_ok;
    logic [DATA_W-1:0]   w_step_hi;
    logic [DATA_W-1:0]   w_step_lo;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_zero_div;
    logic                w_last;

    assign w_a_mag = r_a[DATA_W-1] ? -r_a : r_a;
    assign w_b_mag = r_b[DATA_W-1] ? -r_b : r_b;

    // Multiply: conditional add of the multiplicand into the upper half, then shift the pair right.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);

    // Divide (restoring): shift the next dividend bit into the remainder, keep the difference if non-negative.
    assign w_div_sh   = {r_hi, r_lo[DATA_W-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_m};
    assign w_div_ok   = ~w_div_diff[DATA_W];

    assign w_step_hi = r_op ? (w_div_ok ? w_div_diff[DATA_W-1:0] : w_div_sh[DATA_W-1:0])
                            : w_mul_sum[DATA_W:1];
    assign w_step_lo = r_op ? {r_lo[DATA_W-2:0], w_div_ok}
                            : {w_mul_sum[0], r_lo[DATA_W-1:1]};

    assign w_prod     = r_neg_q ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};
    assign w_zero_div = (r_state == S_PREP) && r_op && (r_b == '0);
    assign w_last     = (r_state == S_ITER) && (r_cnt == '0);

    assign done     = w_zero_div || w_last;
    assign busy     = r_busy;
    assign div_zero = r_div_zero;

    always_comb begin
        hi = w_prod[2*DATA_W-1:DATA_W];
        lo = w_prod[DATA_W-1:0];
        if (w_zero_div) begin
            hi = r_a;
            lo = '1;
        end else if (r_op) begin
            hi = r_neg_r ? -w_step_hi : w_step_hi;
            lo = r_neg_q ? -w_step_lo : w_step_lo;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= 1'b0;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_m        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_op       <= op;
                        r_div_zero <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_neg_q <= r_a[DATA_W-1] ^ r_b[DATA_W-1];
                    r_neg_r <= r_a[DATA_W-1];
                    r_hi    <= '0;
                    r_cnt   <= CNT_W'(DATA_W - 1);
                    if (w_zero_div) begin
                        r_div_zero <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_m     <= r_op ? w_b_mag : w_a_mag;
                        r_lo    <= r_op ? w_a_mag : w_b_mag;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_hi <= w_step_hi;
                    r_lo <= w_step_lo;
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/param_data_path.sv
// Shared-bus CPU datapath: register file, special registers, single-cycle ALU into Z, iterative mul/div.
// Bus and ALU are combinational; mul/div results land DATA_W+1 edges after launch, starts while busy are dropped.
module param_data_path
    import data_path_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int R0_ZERO  = 0
) (
    input  logic               clock,
    input  logic               clear,
    param_data_path_if.slave   dp
);
    localparam int RSEL_W = $clog2(NUM_REGS);
    localparam int SH_W   = $clog2(DATA_W);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_zhigh;
    logic [DATA_W-1:0] r_zlow;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_inport;
    logic [DATA_W-1:0] r_y;
    logic              r_done;

    logic [DATA_W-1:0]   w_bus;
    logic [DATA_W-1:0]   w_alu_hi;
    logic [DATA_W-1:0]   w_alu_lo;
    logic [DATA_W:0]     w_add;
    logic [DATA_W:0]     w_sub;
    logic [SH_W-1:0]     w_sh;
    logic [2*DATA_W-1:0] w_rot_r;
    logic [2*DATA_W-1:0] w_rot_l;
    logic                w_md_start;
    logic                w_md_busy;
    logic                w_md_done;
    logic                w_md_dz;
    logic [DATA_W-1:0]   w_md_hi;
    logic [DATA_W-1:0]   w_md_lo;
    logic                w_r0_wr;
    int                  w_sel;

    // Bus source decode
    always_comb begin
        w_bus = '0;
        w_sel = int'(dp.bus_sel);
        if (w_sel < NUM_REGS) begin
            if (!(R0_ZERO != 0 && w_sel == 0))
                w_bus = r_regs[dp.bus_sel[RSEL_W-1:0]];
        end else begin
            case (w_sel - NUM_REGS)
                SRC_HI:     w_bus = r_hi;
                SRC_LO:     w_bus = r_lo;
                SRC_ZHIGH:  w_bus = r_zhigh;
                SRC_ZLOW:   w_bus = r_zlow;
                SRC_PC:     w_bus = r_pc;
                SRC_MDR:    w_bus = r_mdr;
                SRC_INPORT: w_bus = r_inport;
                default:    w_bus = '0;
            endcase
        end
    end

    assign w_add   = {1'b0, r_y} + {1'b0, w_bus};
    assign w_sub   = {1'b0, r_y} - {1'b0, w_bus};
    assign w_sh    = w_bus[SH_W-1:0];
    assign w_rot_r = {r_y, r_y} >> w_sh;
    assign w_rot_l = {r_y, r_y} << w_sh;

    // NEG and NOT are unary on the bus operand.
    always_comb begin
        w_alu_hi = '0;
        w_alu_lo = '0;
        case (dp.alu_op)
            OP_ADD: begin
                w_alu_lo = w_add[DATA_W-1:0];
                w_alu_hi = {{(DATA_W-1){1'b0}}, w_add[DATA_W]};
            end
            OP_SUB: begin
                w_alu_lo = w_sub[DATA_W-1:0];
                w_alu_hi = {{(DATA_W-1){1'b0}}, w_sub[DATA_W]};
            end
            OP_AND:  w_alu_lo = r_y & w_bus;
            OP_OR:   w_alu_lo = r_y | w_bus;
            OP_SHR:  w_alu_lo = r_y >> w_sh;
            OP_SHRA: w_alu_lo = $signed(r_y) >>> w_sh;
            OP_SHL:  w_alu_lo = r_y << w_sh;
            OP_ROR:  w_alu_lo = w_rot_r[DATA_W-1:0];
            OP_ROL:  w_alu_lo = w_rot_l[2*DATA_W-1:DATA_W];
            OP_NEG:  w_alu_lo = -w_bus;
            OP_NOT:  w_alu_lo = ~w_bus;
            default: ;
        endcase
    end

    assign w_md_start = dp.alu_start && !w_md_busy &&
                        (dp.alu_op == OP_MUL || dp.alu_op == OP_DIV);

    iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clock    (clock),
        .clear    (clear),
        .start    (w_md_start),
        .op       (dp.alu_op == OP_DIV),
        .a        (r_y),
        .b        (w_bus),
        .busy     (w_md_busy),
        .done     (w_md_done),
        .div_zero (w_md_dz),
        .hi       (w_md_hi),
        .lo       (w_md_lo)
    );

    assign w_r0_wr = (R0_ZERO != 0) && (dp.reg_wr_sel == '0);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (dp.reg_wr_en && !w_r0_wr) begin
            r_regs[dp.reg_wr_sel] <= w_bus;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_pc     <= '0;
            r_mdr    <= '0;
            r_inport <= '0;
            r_y      <= '0;
        end else begin
            if (dp.HIin)     r_hi     <= w_bus;
            if (dp.LOin)     r_lo     <= w_bus;
            if (dp.PCin)     r_pc     <= w_bus;
            if (dp.Yin)      r_y      <= w_bus;
            if (dp.InPortin) r_inport <= dp.in_port_data;
            if (dp.MDRin)    r_mdr    <= dp.Read ? dp.MDataIn : w_bus;
        end
    end

    // A completing mul/div owns Z; Zin only lands when the unit is idle.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_zhigh <= '0;
            r_zlow  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_md_done;
            if (w_md_done) begin
                r_zhigh <= w_md_hi;
                r_zlow  <= w_md_lo;
            end else if (dp.Zin && !w_md_busy) begin
                r_zhigh <= w_alu_hi;
                r_zlow  <= w_alu_lo;
            end
        end
    end

    assign dp.bus_out  = w_bus;
    assign dp.mdr_out  = r_mdr;
    assign dp.pc_out   = r_pc;
    assign dp.busy     = w_md_busy;
    assign dp.done     = r_done;
    assign dp.div_zero = w_md_dz;

endmodule
